// File: rtl/line_clear_engine.sv
// Line-clear engine: scans a captured board from the bottom row up, removes every
// full row by shifting the rows above it down one, then publishes the compacted board.
module line_clear_engine #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ROWS-1:0][COLS-1:0]  screen_in,
    output logic [ROWS-1:0][COLS-1:0]  screen_out,
    output logic                       clearing_line,
    output logic                       done,
    output logic [2:0]                 lines_cleared,
    output logic [15:0]                total_lines,
    output logic                       game_over,
    output logic [1:0]                 fsm_state
);

    // Handshake: start is accepted only while idle (clearing_line=0); it is a one-cycle
    // pulse with no queueing. done pulses for one cycle when screen_out/lines_cleared are valid.
    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(ROWS + 1);

    state_t                      state;
    logic [RW-1:0]               row;
    logic [CW-1:0]               cnt;
    logic [ROWS-1:0][COLS-1:0]   buffer;
    logic                        row_full;
    logic [16:0]                 total_sum;
    logic [2:0]                  cnt_sat;

    assign row_full  = &buffer[row];
    assign total_sum = {1'b0, total_lines} + 17'(cnt);
    assign cnt_sat   = (32'(cnt) > 7) ? 3'd7 : 3'(cnt);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            row           <= RW'(ROWS - 1);
            cnt           <= '0;
            buffer        <= '0;
            screen_out    <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
            game_over     <= 1'b0;
            clearing_line <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        buffer        <= screen_in;
                        row           <= RW'(ROWS - 1);
                        cnt           <= '0;
                        clearing_line <= 1'b1;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        state <= SHIFT;
                    end else if (row == '0) begin
                        screen_out    <= buffer;
                        lines_cleared <= cnt_sat;
                        total_lines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                        if (|buffer[0]) game_over <= 1'b1;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        row <= row - 1'b1;
                    end
                end
                SHIFT: begin
                    // Rows at or above the cleared row drop by one; rows below stay put.
                    for (int r = 1; r < ROWS; r++) begin
                        if (r <= int'(row)) buffer[r] <= buffer[r-1];
                    end
                    buffer[0] <= '0;
                    cnt       <= cnt + 1'b1;
                    state     <= SCAN;
                end
                DONE: begin
                    done          <= 1'b0;
                    clearing_line <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: per-scenario tasks with hand-computed boards,
// latencies and counters.
module tb_line_clear_engine;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    board_t       screen_in;
    board_t       screen_out;
    logic         clearing_line;
    logic         done;
    logic [2:0]   lines_cleared;
    logic [15:0]  total_lines;
    logic         game_over;
    logic [1:0]   fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    line_clear_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .reset(reset), .start(start), .screen_in(screen_in),
        .screen_out(screen_out), .clearing_line(clearing_line), .done(done),
        .lines_cleared(lines_cleared), .total_lines(total_lines),
        .game_over(game_over), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Pulses start with the given board and watches the busy window. restart_at/reset_at
    // inject a second start or a reset when the busy count reaches that value (0 = never).
    task automatic run_op(input board_t board, input int restart_at, input int reset_at,
                          output int busy, output int dcnt, output int dat);
        busy = 0; dcnt = 0; dat = 0;
        screen_in = board; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!clearing_line) break;
            busy++;
            if (done) begin dcnt++; dat = busy; end
            start = (busy == restart_at);
            if (start) screen_in = '1;
            reset = (busy == reset_at);
            @(posedge clk); #1;
        end
        start = 1'b0; reset = 1'b0;
        n_checks++;
        if (clearing_line) begin
            n_fail++;
            $display("FAIL busy_timeout: clearing_line still high after %0d cycles, required low", busy);
        end
    endtask

    task automatic check_op(input string name, input int busy, input int dcnt, input int dat,
                            input int exp_busy, input board_t exp_board, input int exp_lc,
                            input int exp_total);
        n_checks++;
        if (busy !== exp_busy) begin
            n_fail++; $display("FAIL %s_busy: got %0d cycles, required %0d", name, busy, exp_busy);
        end
        n_checks++;
        if (dcnt !== 1 || dat !== exp_busy) begin
            n_fail++; $display("FAIL %s_done: got %0d pulses at cycle %0d, required 1 at %0d", name, dcnt, dat, exp_busy);
        end
        n_checks++;
        if (screen_out !== exp_board) begin
            n_fail++; $display("FAIL %s_screen: got %h, required %h", name, screen_out, exp_board);
        end
        n_checks++;
        if (lines_cleared !== 3'(exp_lc)) begin
            n_fail++; $display("FAIL %s_lines: got %0d, required %0d", name, lines_cleared, exp_lc);
        end
        n_checks++;
        if (total_lines !== 16'(exp_total)) begin
            n_fail++; $display("FAIL %s_total: got %0d, required %0d", name, total_lines, exp_total);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (clearing_line !== 1'b0 || done !== 1'b0 || game_over !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy=%b done=%b go=%b, required 0 0 0", clearing_line, done, game_over);
        end
        n_checks++;
        if (screen_out !== '0 || lines_cleared !== 3'd0 || total_lines !== 16'd0) begin
            n_fail++; $display("FAIL reset_outputs: screen=%h lc=%0d total=%0d, required all 0", screen_out, lines_cleared, total_lines);
        end
        // start coincident with reset must not launch an op
        reset = 1'b1; start = 1'b1; screen_in = '1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (clearing_line !== 1'b0) begin
            n_fail++; $display("FAIL reset_start_ignored: clearing_line=%b, required 0", clearing_line);
        end
    endtask

    task automatic test_empty();
        int busy, dcnt, dat;
        run_op('0, 0, 0, busy, dcnt, dat);
        check_op("empty", busy, dcnt, dat, 21, '0, 0, 0);
    endtask

    task automatic test_single();
        int busy, dcnt, dat;
        board_t b, e;
        b = '0; b[19] = 10'h3FF; b[18] = 10'h001;
        e = '0; e[19] = 10'h001;
        run_op(b, 0, 0, busy, dcnt, dat);
        check_op("single", busy, dcnt, dat, 23, e, 1, 1);
    endtask

    task automatic test_tetris();
        int busy, dcnt, dat;
        board_t b, e;
        b = '0; for (int r = 16; r < 20; r++) b[r] = 10'h3FF; b[15] = 10'h155;
        e = '0; e[19] = 10'h155;
        run_op(b, 0, 0, busy, dcnt, dat);
        check_op("tetris", busy, dcnt, dat, 29, e, 4, 5);
    endtask

    task automatic test_split();
        int busy, dcnt, dat;
        board_t b, e;
        b = '0; b[19] = 10'h3FF; b[18] = 10'h0AA; b[17] = 10'h3FF; b[16] = 10'h201;
        e = '0; e[19] = 10'h0AA; e[18] = 10'h201;
        run_op(b, 0, 0, busy, dcnt, dat);
        check_op("split", busy, dcnt, dat, 25, e, 2, 7);
    endtask

    task automatic test_back_to_back();
        int busy, dcnt, dat;
        run_op('0, 3, 0, busy, dcnt, dat);
        check_op("restart_ignored", busy, dcnt, dat, 21, '0, 0, 7);
        @(posedge clk); #1;
        n_checks++;
        if (clearing_line !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL restart_idle: busy=%b done=%b, required 0 0", clearing_line, done);
        end
        run_op('1, 0, 5, busy, dcnt, dat);
        n_checks++;
        if (busy !== 5 || dcnt !== 0) begin
            n_fail++; $display("FAIL abort: busy %0d cycles %0d dones, required 5 and 0", busy, dcnt);
        end
        n_checks++;
        if (total_lines !== 16'd0 || lines_cleared !== 3'd0 || fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL abort_state: total=%0d lc=%0d state=%0d, required 0 0 0", total_lines, lines_cleared, fsm_state);
        end
    endtask

    task automatic test_game_over();
        int busy, dcnt, dat;
        board_t b, e;
        do_reset();
        b = '0; b[0] = 10'h010; b[19] = 10'h3FF;
        e = '0; e[1] = 10'h010;
        run_op(b, 0, 0, busy, dcnt, dat);
        check_op("top_drop", busy, dcnt, dat, 23, e, 1, 1);
        n_checks++;
        if (game_over !== 1'b0) begin
            n_fail++; $display("FAIL top_drop_go: got %b, required 0", game_over);
        end
        b = '0; for (int r = 0; r < 19; r++) b[r] = 10'h1FF;
        run_op(b, 0, 0, busy, dcnt, dat);
        check_op("stacked", busy, dcnt, dat, 21, b, 0, 1);
        n_checks++;
        if (game_over !== 1'b1) begin
            n_fail++; $display("FAIL stacked_go: got %b, required 1", game_over);
        end
        run_op('0, 0, 0, busy, dcnt, dat);
        n_checks++;
        if (game_over !== 1'b1) begin
            n_fail++; $display("FAIL go_sticky: got %b, required 1", game_over);
        end
        do_reset();
        n_checks++;
        if (game_over !== 1'b0) begin
            n_fail++; $display("FAIL go_reset: got %b, required 0", game_over);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; screen_in = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_empty();
        test_single();
        test_tetris();
        test_split();
        test_back_to_back();
        test_game_over();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 The block SHALL have parameter ROWS, default 20, board height in rows; row 0 is top, row ROWS-1 is bottom.
REQ-002 The block SHALL have parameter COLS, default 10, board width in columns.
REQ-003 The block SHALL have port clk  input  1  the single clock for all state; one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port start  input  1  one-cycle pulse meaning a piece has locked and screen_in must be processed.
REQ-006 The block SHALL have port screen_in  input  ROWS x COLS  fixed board with the landed piece merged; 1 means occupied.
REQ-007 The block SHALL have port screen_out  output  ROWS x COLS  compacted board, registered.
REQ-008 The block SHALL have port clearing_line  output  1  busy flag; high while a clear operation is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking that screen_out and lines_cleared are valid.
REQ-010 The block SHALL have port lines_cleared  output  3  count of full rows removed by the most recent operation, 0 to 4.
REQ-011 The block SHALL have port total_lines  output  16  running total of cleared lines; saturates at 16'hFFFF.
REQ-012 The block SHALL have port game_over  output  1  sticky flag; set when row 0 of the compacted board is non-zero.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SCAN, SHIFT, DONE.
REQ-014 In IDLE, start=1 SHALL capture screen_in into an internal buffer, set row index to ROWS-1, zero a per-op counter, and enter SCAN.
REQ-015 start SHALL be ignored in every state other than IDLE; there SHALL be no queueing.
REQ-016 In SCAN, if buffer[row] is all ones, the FSM SHALL enter SHIFT and keep the row index unchanged.
REQ-017 In SCAN, if buffer[row] is not full and row=0, the FSM SHALL enter DONE.
REQ-018 In SCAN, if buffer[row] is not full and row>0, the row index SHALL decrement and the FSM SHALL stay in SCAN.
REQ-019 SHIFT SHALL take one cycle: buffer[r] <= buffer[r-1] for 1<=r<=row, buffer[0] <= 0, rows below row unchanged, per-op counter +1; the FSM then returns to SCAN on the same row so that it re-checks the row.
REQ-020 On the SCAN->DONE edge, the block SHALL load screen_out <= buffer and lines_cleared <= per-op counter.
REQ-021 On the same SCAN->DONE edge, the block SHALL load total_lines <= min(total_lines + counter, 16'hFFFF).
REQ-022 On the same SCAN->DONE edge, game_over SHALL set if buffer row 0 is non-zero.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 clearing_line SHALL be 1 in SCAN, SHIFT and DONE, and 0 in IDLE.
REQ-025 Latency with k full rows: clearing_line SHALL be high for exactly 21+2k cycles, starting the cycle after start is sampled; done SHALL be high in the last of those cycles.
REQ-026 screen_out, lines_cleared and total_lines SHALL hold their values between operations.
REQ-027 game_over SHALL clear only on reset.
REQ-028 A row with any zero bit SHALL never be removed.
REQ-029 Column order SHALL be preserved in all row moves.

Reset
REQ-030 reset SHALL have priority over all other inputs and SHALL take effect on the next rising edge of clk.
REQ-031 Reset SHALL force the FSM to IDLE and row index to ROWS-1.
REQ-032 Reset SHALL clear the buffer, screen_out, lines_cleared, total_lines, game_over, clearing_line and done to 0.
REQ-033 Reset during SCAN or SHIFT SHALL abort the operation with no done pulse and no update of total_lines.
REQ-034 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-035 The bench SHALL cover: empty board, start -> clearing_line high 21 cycles; done in cycle 21; lines_cleared=0; screen_out all 0; total_lines=0.
REQ-036 The bench SHALL cover: row19=3FF, row18=001, other rows 0 -> busy 23 cycles; row19=001; row18=000; lines_cleared=1; total_lines=1.
REQ-037 The bench SHALL cover: rows 16-19=3FF, row15=155 -> busy 29 cycles; row19=155; rows 0-18=0; lines_cleared=4.
REQ-038 The bench SHALL cover: row19=3FF, row18=0AA, row17=3FF, row16=201 -> row19=0AA; row18=201; rows 0-17=0; lines_cleared=2 (non-adjacent rows, each full row re-checked after its shift).
REQ-039 The bench SHALL cover: start pulsed again at cycle 3 of an op -> ignored, one done pulse only; separately, reset asserted at cycle 5 -> IDLE next cycle, no done, total_lines=0.
REQ-040 The bench SHALL cover: row0=010, row19=3FF -> after done, row0=0, row1=010, game_over=0; board with rows 0-18 each 1FF (not full), no full rows -> game_over=1 and it stays 1 across a following op until reset.
